// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the valid/ready
// instruction port toward decode (including the decoder's jump feedback).
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
  logic [5:0]  funct_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        jump_i;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_o, op_o, funct_o, pc_o, pc_plus4_o,
    input  imem_ack, imem_rdata, instr_ready, jump_i
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_o, op_o, funct_o, pc_o, pc_plus4_o,
    output imem_ack, imem_rdata, instr_ready, jump_i
  );
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction fetch stage: PC register, imem req/ack fetch, valid/ready hand-off
// to decode, sequential or J-type next PC. Define IFETCH_PERF_CNT_EN for perf counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_instr_cnt,
  output logic [31:0]   perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        accept;
  logic        fetch_done;

  assign pc_plus4   = pc_reg + 32'd4;
  // J-type target keeps the region bits of pc+4 (after any wrap) above the 28-bit field.
  assign pc_target  = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
  assign accept     = (state_reg == HOLD) && bus.instr_ready;
  assign fetch_done = (state_reg == REQ) && bus.imem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = REQ;
      REQ:     if (bus.imem_ack) state_next = HOLD;
      HOLD:    if (bus.instr_ready) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    case (state_reg)
      REQ:     bus.imem_req = 1'b1;
      HOLD:    bus.instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      instr_reg <= 32'd0;
    end else begin
      if (fetch_done) begin
        instr_reg <= bus.imem_rdata;
      end
      if (accept) begin
        pc_reg <= bus.jump_i ? pc_target : pc_plus4;
      end
    end
  end

  assign bus.imem_addr  = {pc_reg[31:2], 2'b00};
  assign bus.instr_o    = instr_reg;
  assign bus.op_o       = instr_reg[31:26];
  assign bus.funct_o    = instr_reg[5:0];
  assign bus.pc_o       = pc_reg;
  assign bus.pc_plus4_o = pc_plus4;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] instr_cnt_reg;
  logic [31:0] wait_cnt_reg;
  logic        wait_cycle;

  // Stall cycles: memory not answering, or decode not taking the held word.
  assign wait_cycle = ((state_reg == REQ) && !bus.imem_ack) ||
                      ((state_reg == HOLD) && !bus.instr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_reg <= 32'd0;
      wait_cnt_reg  <= 32'd0;
    end else begin
      if (accept) begin
        instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
      if (wait_cycle) begin
        wait_cnt_reg <= wait_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_instr_cnt = instr_cnt_reg;
  assign perf_wait_cnt  = wait_cnt_reg;
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction decoder/controller in the MIPS core.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Presents each fetched word with op/funct fields and a valid/ready handshake to decode.
- Computes the next PC as sequential (+4) or the J-type target, selected by the decoder's jump signal returned on the accept cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  byte address of the requested word (= pc)
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
instr_valid  out  1  instr_o holds a fetched instruction
instr_ready  in  1  decode/datapath consumes instruction this cycle
instr_o  out  32  held instruction word
op_o  out  6  instr_o[31:26], to decoder op_i
funct_o  out  6  instr_o[5:0], to decoder funct_i
pc_o  out  32  address of instr_o
pc_plus4_o  out  32  pc_o + 4
jump_i  in  1  decoder jump output; sampled only on accept cycle

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, pc=RESET_PC, instr_o=0, instr_valid=0, imem_req=0. Reset overrides everything, including an in-flight request; an ack arriving in IDLE is ignored.
- States:
  - IDLE: outputs idle; next state REQ unconditionally (one bubble after reset).
  - REQ: imem_req=1, imem_addr=pc, held stable until ack.
    - imem_ack=1: instr_o<=imem_rdata, instr_valid<=1, next HOLD.
    - Otherwise stay in REQ; there is no timeout.
  - HOLD: imem_req=0, instr_valid=1, instr_o/pc_o stable.
    - Accept = instr_valid & instr_ready.
    - On accept: pc <= jump_i ? {pc_plus4[31:28], instr_o[25:0], 2'b00} : pc+4, instr_valid<=0, next REQ.
    - Otherwise stay in HOLD.
- Minimum throughput: one instruction per 2 cycles. Zero-wait memory with ready tied high: REQ, HOLD, REQ, HOLD, ...
- Latency: instr_valid rises the cycle after the ack edge.
- op_o, funct_o, pc_plus4_o are combinational from instr_o/pc_o; pc_o is the current pc register.
- Arithmetic is modulo 2^32: pc 0xFFFF_FFFC +4 wraps to 0x0000_0000. The jump target uses upper bits of pc+4 after wrap.
- jump_i and instr_ready are ignored outside HOLD. imem_ack is ignored outside REQ.
- imem_addr[1:0] is always 2'b00.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_instr_cnt[31:0], incremented on each accept.
  - Adds outputs perf_wait_cnt[31:0], incremented each cycle in REQ with imem_ack=0 plus each cycle in HOLD with instr_ready=0.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: no counter ports or logic; all other behaviour identical.

Test Plan:
1. Reset, then zero-wait ack, ready=1, jump_i=0.
   - imem_addr sequence: 0x0, 0x4, 0x8, with imem_req high every other cycle.
   - pc_plus4_o=0x4 while pc_o=0x0.
2. Ack delayed 3 cycles at pc=0x8.
   - imem_req and imem_addr=0x8 stay stable for 4 cycles.
   - instr_valid rises one cycle after ack.
   - instr_o equals the acked word (e.g. 0x2008_0005 gives op_o=0x08).
3. instr_ready=0 for 5 cycles in HOLD.
   - instr_valid stays 1 and instr_o/pc_o are unchanged.
   - No imem_req; next fetch starts the cycle after ready=1.
4. instr_o=0x0800_0010 at pc=0x0040_0000, jump_i=1 on accept.
   - Next imem_addr=0x0000_0040.
   - jump_i=1 while ready=0 has no effect.
5. RESET_PC=0xFFFF_FFFC, one sequential accept: next imem_addr=0x0000_0000.
6. rst asserted while in REQ, with ack arriving in the same cycle.
   - Ack is discarded; instr_valid=0.
   - Next request is to RESET_PC after the IDLE bubble.
   - With IFETCH_PERF_CNT_EN, both counters read 0.
